// File: rtl/unstripe_sched_if.sv
`timescale 1ns/1ps
// Lane inputs and merged output of the two-lane unstriper.
// The driving side is master; the merge block is slave.
interface unstripe_sched_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] lane0;
  logic              valid0;
  logic [DATA_W-1:0] lane1;
  logic              valid1;
  logic [DATA_W-1:0] dataOut;
  logic              validOut;

  modport master (
    output lane0, valid0,
    output lane1, valid1,
    input  dataOut, validOut
  );

  modport slave (
    input  lane0, valid0,
    input  lane1, valid1,
    output dataOut, validOut
  );
endinterface

// File: rtl/unstripe_sched.sv
`timescale 1ns/1ps
// Two-lane unstriper: per-lane FIFOs merged by a
// lane0/lane1 alternating scheduler, one word per clock.
module unstripe_sched #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int FW     = AW + 1
) (
  input  logic              clk_2f,
  input  logic              reset,
  unstripe_sched_if.slave   bus,
  input  logic              enable,
  output logic [FW-1:0]     fill0,
  output logic [FW-1:0]     fill1,
  output logic              ovf0,
  output logic              ovf1,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEL0 = 2'b01,
    SEL1 = 2'b10
  } st_t;

  logic              rst_meta;
  logic              rst_n;
  logic [DATA_W-1:0] din  [2];
  logic [DATA_W-1:0] head [2];
  logic [FW-1:0]     cnt  [2];
  logic [1:0]        vin;
  logic [1:0]        pop;
  logic [1:0]        empty;
  logic [1:0]        ovf;
  st_t               st;
  st_t               st_nx;
  logic [DATA_W-1:0] dout;
  logic              vout;

  // Assert asynchronously, release on the clock.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  assign din[0] = bus.lane0;
  assign din[1] = bus.lane1;
  assign vin    = {bus.valid1, bus.valid0};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [FW-1:0]     c;
    logic              o;
    logic              full;
    logic              push;

    assign full     = (c == FW'(DEPTH));
    assign push     = vin[g] && (!full || pop[g]);
    assign head[g]  = mem[rp];
    assign cnt[g]   = c;
    assign ovf[g]   = o;
    assign empty[g] = (c == '0);

    // Storage carries no reset; occupancy gates every read.
    always_ff @(posedge clk_2f) begin
      if (push) mem[wp] <= din[g];
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_2f or negedge rst_n) begin
      if (!rst_n) begin
        wp <= '0;
        rp <= '0;
        c  <= '0;
        o  <= 1'b0;
      end else begin
        if (push) wp <= wp + AW'(1);
        if (pop[g]) rp <= rp + AW'(1);
        if (push && !pop[g]) c <= c + FW'(1);
        else if (!push && pop[g]) c <= c - FW'(1);
        if (vin[g] && full && !pop[g]) o <= 1'b1;
      end
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk_2f or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  // Lane selection; a lane1 word is owed before stopping.
  always_comb begin
    st_nx = st;
    pop   = 2'b00;
    case (st)
      IDLE: begin
        if (enable) st_nx = SEL0;
      end
      SEL0: begin
        if (!enable) begin
          st_nx = IDLE;
        end else if (!empty[0]) begin
          pop[0] = 1'b1;
          st_nx  = SEL1;
        end
      end
      SEL1: begin
        if (!empty[1]) begin
          pop[1] = 1'b1;
          st_nx  = enable ? SEL0 : IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  // Registered merged output; data holds when idle.
  always_ff @(posedge clk_2f or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      vout <= 1'b0;
    end else begin
      vout <= |pop;
      if (pop[0])      dout <= head[0];
      else if (pop[1]) dout <= head[1];
    end
  end

  assign bus.dataOut  = dout;
  assign bus.validOut = vout;
  assign fill0        = cnt[0];
  assign fill1        = cnt[1];
  assign ovf0         = ovf[0];
  assign ovf1         = ovf[1];
  assign state        = st;

endmodule
